riscv_rob_ctrl: RTL and testbench
=================================

RISCV_ROB_CTRL -- requirements
Module: riscv_rob_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of reorder-buffer slots, power of two, slot index width 5.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have ports alloc_val_0, alloc_val_1  input  1  dispatch of the older and younger instruction; alloc_val_1 is meaningful only with alloc_val_0.
REQ-005 SHALL have ports alloc_wen_0, alloc_wen_1  input  1  instruction writes the register file.
REQ-006 SHALL have ports alloc_waddr_0, alloc_waddr_1  input  5  destination register.
REQ-007 SHALL have port alloc_rdy  output  1  two or more free slots exist.
REQ-008 SHALL have ports alloc_slot_0, alloc_slot_1  output  5  slot granted to each instruction (tail, tail+1 mod DEPTH).
REQ-009 SHALL have ports fill_wen_A, fill_wen_B  input  1 and fill_slot_A, fill_slot_B  input  5  result writeback marking.
REQ-010 SHALL have ports commit_val_1, commit_val_2  output  1  oldest/second-oldest entry retires this cycle.
REQ-011 SHALL have ports commit_wen_1, commit_wen_2  output  1 and commit_slot_1/2, commit_waddr_1/2  output  5  register-file commit request.
REQ-012 SHALL have port flush  input  1  squash all entries.
REQ-013 SHALL have ports full, empty  output  1 and count  output  6  occupancy.

Function
REQ-014 SHALL keep per-slot state valid, filled, wen, waddr; head and tail pointers with wrap bit; count = tail - head.
REQ-015 SHALL allocate at the edge only when alloc_rdy=1: alloc_val_0 takes tail, alloc_val_1 takes tail+1; entries set valid=1, filled=0; tail advances by number allocated, wrapping mod DEPTH.
REQ-016 SHALL drive alloc_rdy = (DEPTH - count >= 2), from current count only; same-cycle commits grant no credit.
REQ-017 SHALL ignore alloc_val_* while alloc_rdy=0 (requester holds).
REQ-018 SHALL set filled=1 at the edge for each fill port whose slot is valid; fills to invalid slots ignored; A and B to the same slot equals one fill.
REQ-019 SHALL assert commit_val_1 combinationally when head entry valid and filled; commit_val_2 only when commit_val_1 and head+1 valid and filled (in-order, never skip).
REQ-020 SHALL drive commit_wen_n = commit_val_n & entry wen; commit_slot_n/commit_waddr_n from the entry; wen=0 entries retire without a register write.
REQ-021 SHALL at the edge clear valid of committed entries and advance head by number committed.
REQ-022 SHALL apply allocate, fill and commit in the same cycle independently; count_next = count + allocs - commits.
REQ-023 SHALL on flush clear all valid/filled, set head=tail=0, force commit_val_*=0 that cycle, and ignore same-cycle alloc and fill.
REQ-024 SHALL drive full = (count==DEPTH), empty = (count==0).

Reset
REQ-025 SHALL on reset=0 immediately clear all valid/filled, head=tail=0; outputs: count=0, empty=1, full=0, alloc_rdy=1, alloc_slot_0=0, alloc_slot_1=1, all commit_* =0.
REQ-026 SHALL abandon in-flight entries when reset asserts mid-operation; no commit after release until new allocation and fill.

Configuration
REQ-027 SHALL with RISCV_ROB_CTRL_FILL_BYPASS_EN defined treat a same-cycle fill to the head (or head+1) slot as filled for commit evaluation, giving fill-to-commit latency 0 cycles.
REQ-028 SHALL without RISCV_ROB_CTRL_FILL_BYPASS_EN commit only from registered filled bits: fill-to-commit latency 1 cycle.

Verification
REQ-029 SHALL cover: reset, alloc pair (wen=1, waddr 3,4) -> slots 0,1; count=2; fill both -> next cycle commit_val_1/2=1, waddr 3,4, count=0.
REQ-030 SHALL cover: fill slot 1 only -> no commit; then fill slot 0 -> both commit same cycle (in order).
REQ-031 SHALL cover: allocate 31 entries -> alloc_rdy=0; commit 1 -> alloc_rdy=1 next cycle; tail wraps 31->0 with correct slot numbers.
REQ-032 SHALL cover: 32 allocated, flush with alloc_val_0=1 -> count=0, empty=1, alloc_slot_0=0, no commits.
REQ-033 SHALL cover: fill head with wen=0 entry -> commit_val_1=1, commit_wen_1=0; with bypass macro commit same cycle as fill, without it one cycle later.
REQ-034 SHALL cover: reset asserted asynchronously between edges with 5 entries -> outputs return to REQ-025 values before the next clock edge.

Source files
------------

// File: rtl/riscv_rob_ctrl.sv
// Reorder-buffer control: 2-wide allocate, 2-port result fill, 2-wide in-order commit.
// Define RISCV_ROB_CTRL_FILL_BYPASS_EN to let a same-cycle fill of head/head+1 commit immediately.
module riscv_rob_ctrl #(
    parameter  int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_val_0,
    input  logic             alloc_val_1,
    input  logic             alloc_wen_0,
    input  logic             alloc_wen_1,
    input  logic [4:0]       alloc_waddr_0,
    input  logic [4:0]       alloc_waddr_1,
    output logic             alloc_rdy,
    output logic [IDX_W-1:0] alloc_slot_0,
    output logic [IDX_W-1:0] alloc_slot_1,
    input  logic             fill_wen_A,
    input  logic             fill_wen_B,
    input  logic [IDX_W-1:0] fill_slot_A,
    input  logic [IDX_W-1:0] fill_slot_B,
    output logic             commit_val_1,
    output logic             commit_val_2,
    output logic             commit_wen_1,
    output logic             commit_wen_2,
    output logic [IDX_W-1:0] commit_slot_1,
    output logic [IDX_W-1:0] commit_slot_2,
    output logic [4:0]       commit_waddr_1,
    output logic [4:0]       commit_waddr_2,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [IDX_W:0]   count
);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0] head, tail;
    logic [DEPTH-1:0] valid, filled, wen;
    logic [DEPTH-1:0] valid_nxt, filled_nxt;
    logic [4:0]       waddr [DEPTH];
    logic [IDX_W-1:0] head_idx, head1_idx, tail_idx, tail1_idx;
    logic             byp_0, byp_1, rdy_0, rdy_1;
    logic             alloc_fire, alloc_two;
    logic [1:0]       n_alloc, n_commit;

    assign head_idx  = head[IDX_W-1:0];
    assign head1_idx = head_idx + IDX_W'(1);
    assign tail_idx  = tail[IDX_W-1:0];
    assign tail1_idx = tail_idx + IDX_W'(1);

    // Occupancy comes from the pointer difference; the wrap bit separates full from empty.
    assign count        = tail - head;
    assign alloc_rdy    = (DEPTH_P - count) >= PTR_W'(2);
    assign full         = (count == DEPTH_P);
    assign empty        = (count == '0);
    assign alloc_slot_0 = tail_idx;
    assign alloc_slot_1 = tail1_idx;

`ifdef RISCV_ROB_CTRL_FILL_BYPASS_EN
    assign byp_0 = (fill_wen_A && fill_slot_A == head_idx) || (fill_wen_B && fill_slot_B == head_idx);
    assign byp_1 = (fill_wen_A && fill_slot_A == head1_idx) || (fill_wen_B && fill_slot_B == head1_idx);
`else
    assign byp_0 = 1'b0;
    assign byp_1 = 1'b0;
`endif

    assign rdy_0 = valid[head_idx] && (filled[head_idx] || byp_0);
    assign rdy_1 = valid[head1_idx] && (filled[head1_idx] || byp_1);

    // Second retire slot only follows the first, so retirement never skips an entry.
    assign commit_val_1   = rdy_0 && !flush;
    assign commit_val_2   = commit_val_1 && rdy_1;
    assign commit_wen_1   = commit_val_1 && wen[head_idx];
    assign commit_wen_2   = commit_val_2 && wen[head1_idx];
    assign commit_slot_1  = commit_val_1 ? head_idx : '0;
    assign commit_slot_2  = commit_val_2 ? head1_idx : '0;
    assign commit_waddr_1 = commit_val_1 ? waddr[head_idx] : '0;
    assign commit_waddr_2 = commit_val_2 ? waddr[head1_idx] : '0;

    assign alloc_fire = alloc_rdy && alloc_val_0 && !flush;
    assign alloc_two  = alloc_fire && alloc_val_1;
    assign n_alloc    = {1'b0, alloc_fire} + {1'b0, alloc_two};
    assign n_commit   = {1'b0, commit_val_1} + {1'b0, commit_val_2};

    // Fill, then retire, then allocate: a retiring slot drops its filled bit too.
    always_comb begin
        valid_nxt  = valid;
        filled_nxt = filled;
        if (fill_wen_A && valid[fill_slot_A]) filled_nxt[fill_slot_A] = 1'b1;
        if (fill_wen_B && valid[fill_slot_B]) filled_nxt[fill_slot_B] = 1'b1;
        if (commit_val_1) begin
            valid_nxt[head_idx]  = 1'b0;
            filled_nxt[head_idx] = 1'b0;
        end
        if (commit_val_2) begin
            valid_nxt[head1_idx]  = 1'b0;
            filled_nxt[head1_idx] = 1'b0;
        end
        if (alloc_fire) begin
            valid_nxt[tail_idx]  = 1'b1;
            filled_nxt[tail_idx] = 1'b0;
        end
        if (alloc_two) begin
            valid_nxt[tail1_idx]  = 1'b1;
            filled_nxt[tail1_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            valid  <= '0;
            filled <= '0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            valid  <= '0;
            filled <= '0;
        end else begin
            head   <= head + PTR_W'(n_commit);
            tail   <= tail + PTR_W'(n_alloc);
            valid  <= valid_nxt;
            filled <= filled_nxt;
        end
    end

    // Payload is only meaningful while valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            wen[tail_idx]   <= alloc_wen_0;
            waddr[tail_idx] <= alloc_waddr_0;
        end
        if (alloc_two) begin
            wen[tail1_idx]   <= alloc_wen_1;
            waddr[tail1_idx] <= alloc_waddr_1;
        end
    end
endmodule

// File: tb/tb_riscv_rob_ctrl.sv
// Bench for riscv_rob_ctrl: directed scenarios plus a randomized run against a queue-based model.
module tb_riscv_rob_ctrl;
    localparam int DEPTH = 32;
`ifdef RISCV_ROB_CTRL_FILL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0] slot;
        bit         wen;
        logic [4:0] waddr;
        bit         filled;
    } ent_t;

    logic       clk, reset;
    logic       alloc_val_0, alloc_val_1, alloc_wen_0, alloc_wen_1;
    logic [4:0] alloc_waddr_0, alloc_waddr_1;
    logic       alloc_rdy;
    logic [4:0] alloc_slot_0, alloc_slot_1;
    logic       fill_wen_A, fill_wen_B;
    logic [4:0] fill_slot_A, fill_slot_B;
    logic       commit_val_1, commit_val_2, commit_wen_1, commit_wen_2;
    logic [4:0] commit_slot_1, commit_slot_2, commit_waddr_1, commit_waddr_2;
    logic       flush, full, empty;
    logic [5:0] count;

    int tests = 0;
    int fails = 0;

    riscv_rob_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alloc_val_0(alloc_val_0), .alloc_val_1(alloc_val_1),
        .alloc_wen_0(alloc_wen_0), .alloc_wen_1(alloc_wen_1),
        .alloc_waddr_0(alloc_waddr_0), .alloc_waddr_1(alloc_waddr_1),
        .alloc_rdy(alloc_rdy), .alloc_slot_0(alloc_slot_0), .alloc_slot_1(alloc_slot_1),
        .fill_wen_A(fill_wen_A), .fill_wen_B(fill_wen_B),
        .fill_slot_A(fill_slot_A), .fill_slot_B(fill_slot_B),
        .commit_val_1(commit_val_1), .commit_val_2(commit_val_2),
        .commit_wen_1(commit_wen_1), .commit_wen_2(commit_wen_2),
        .commit_slot_1(commit_slot_1), .commit_slot_2(commit_slot_2),
        .commit_waddr_1(commit_waddr_1), .commit_waddr_2(commit_waddr_2),
        .flush(flush), .full(full), .empty(empty), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic idle();
        alloc_val_0 = 0; alloc_val_1 = 0; alloc_wen_0 = 0; alloc_wen_1 = 0;
        alloc_waddr_0 = 0; alloc_waddr_1 = 0;
        fill_wen_A = 0; fill_wen_B = 0; fill_slot_A = 0; fill_slot_B = 0;
        flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic alloc(input bit two, input bit w0, input logic [4:0] a0,
                         input bit w1, input logic [4:0] a1);
        alloc_val_0 = 1'b1; alloc_val_1 = two;
        alloc_wen_0 = w0; alloc_waddr_0 = a0;
        alloc_wen_1 = w1; alloc_waddr_1 = a1;
    endtask

    task automatic fill(input bit ea, input logic [4:0] sa, input bit eb, input logic [4:0] sb);
        fill_wen_A = ea; fill_slot_A = sa;
        fill_wen_B = eb; fill_slot_B = sb;
    endtask

    function automatic bit hit(input logic [4:0] s);
        return (fill_wen_A && fill_slot_A == s) || (fill_wen_B && fill_slot_B == s);
    endfunction

    task automatic test_reset();
        do_reset();
        #2;
        tests++;
        if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL reset_occupancy: count=%0d empty=%b full=%b, required 0 1 0", count, empty, full);
        end
        tests++;
        if (alloc_rdy !== 1'b1 || alloc_slot_0 !== 5'd0 || alloc_slot_1 !== 5'd1) begin
            fails++;
            $display("FAIL reset_alloc: rdy=%b slots=%0d,%0d, required 1 0,1", alloc_rdy, alloc_slot_0, alloc_slot_1);
        end
        tests++;
        if ({commit_val_1, commit_val_2, commit_wen_1, commit_wen_2} !== 4'b0 ||
            commit_slot_1 !== 5'd0 || commit_slot_2 !== 5'd0 ||
            commit_waddr_1 !== 5'd0 || commit_waddr_2 !== 5'd0) begin
            fails++;
            $display("FAIL reset_commit: val=%b%b slot=%0d,%0d waddr=%0d,%0d, required all 0",
                     commit_val_1, commit_val_2, commit_slot_1, commit_slot_2, commit_waddr_1, commit_waddr_2);
        end
    endtask

    task automatic test_alloc_pair();
        do_reset();
        alloc(1, 1, 5'd3, 1, 5'd4);
        #2;
        tests++;
        if (alloc_rdy !== 1'b1 || alloc_slot_0 !== 5'd0 || alloc_slot_1 !== 5'd1) begin
            fails++;
            $display("FAIL pair_slots: rdy=%b slots=%0d,%0d, required 1 0,1", alloc_rdy, alloc_slot_0, alloc_slot_1);
        end
        next_cycle(); idle(); #2;
        tests++;
        if (count !== 6'd2 || empty !== 1'b0) begin
            fails++;
            $display("FAIL pair_count: count=%0d empty=%b, required 2 0", count, empty);
        end
        fill(1, 5'd0, 1, 5'd1);
        #2;
        tests++;
        if (commit_val_1 !== BYP || commit_val_2 !== BYP) begin
            fails++;
            $display("FAIL pair_fill_cycle: val=%b%b, required %b%b", commit_val_1, commit_val_2, BYP, BYP);
        end
        next_cycle(); idle(); #2;
        tests++;
        if (commit_val_1 !== !BYP || commit_val_2 !== !BYP || commit_wen_1 !== !BYP ||
            commit_waddr_1 !== (BYP ? 5'd0 : 5'd3) || commit_waddr_2 !== (BYP ? 5'd0 : 5'd4) ||
            commit_slot_2 !== (BYP ? 5'd0 : 5'd1)) begin
            fails++;
            $display("FAIL pair_commit: val=%b%b wen1=%b waddr=%0d,%0d slot2=%0d, bypass=%b",
                     commit_val_1, commit_val_2, commit_wen_1, commit_waddr_1, commit_waddr_2, commit_slot_2, BYP);
        end
        next_cycle(); #2;
        tests++;
        if (count !== 6'd0 || empty !== 1'b1 || commit_val_1 !== 1'b0) begin
            fails++;
            $display("FAIL pair_drain: count=%0d empty=%b val1=%b, required 0 1 0", count, empty, commit_val_1);
        end
    endtask

    task automatic test_fill_order();
        do_reset();
        alloc(1, 1, 5'd5, 1, 5'd6);
        next_cycle(); idle();
        fill(1, 5'd1, 0, 5'd0);
        #2;
        tests++;
        if (commit_val_1 !== 1'b0 || commit_val_2 !== 1'b0) begin
            fails++;
            $display("FAIL order_young_fill: val=%b%b, required 00", commit_val_1, commit_val_2);
        end
        next_cycle(); idle(); #2;
        tests++;
        if (commit_val_1 !== 1'b0 || commit_val_2 !== 1'b0 || count !== 6'd2) begin
            fails++;
            $display("FAIL order_hold: val=%b%b count=%0d, required 00 2", commit_val_1, commit_val_2, count);
        end
        fill(0, 5'd0, 1, 5'd0);
        #2;
        tests++;
        if (commit_val_1 !== BYP || commit_val_2 !== BYP) begin
            fails++;
            $display("FAIL order_head_fill: val=%b%b, required %b%b", commit_val_1, commit_val_2, BYP, BYP);
        end
        next_cycle(); idle(); #2;
        tests++;
        if (commit_val_1 !== !BYP || commit_val_2 !== !BYP ||
            commit_slot_2 !== (BYP ? 5'd0 : 5'd1) || commit_waddr_1 !== (BYP ? 5'd0 : 5'd5)) begin
            fails++;
            $display("FAIL order_both: val=%b%b slot2=%0d waddr1=%0d, bypass=%b",
                     commit_val_1, commit_val_2, commit_slot_2, commit_waddr_1, BYP);
        end
        next_cycle(); #2;
        tests++;
        if (count !== 6'd0) begin
            fails++;
            $display("FAIL order_drain: count=%0d, required 0", count);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            alloc(1, 1, 5'(i), 1, 5'(i + 1));
            next_cycle();
        end
        idle(); #2;
        tests++;
        if (count !== 6'd30 || alloc_rdy !== 1'b1) begin
            fails++;
            $display("FAIL wrap_30: count=%0d rdy=%b, required 30 1", count, alloc_rdy);
        end
        alloc(0, 1, 5'd20, 0, 5'd0);
        next_cycle(); idle(); #2;
        tests++;
        if (count !== 6'd31 || alloc_rdy !== 1'b0 || alloc_slot_0 !== 5'd31 || full !== 1'b0) begin
            fails++;
            $display("FAIL wrap_31: count=%0d rdy=%b slot0=%0d full=%b, required 31 0 31 0",
                     count, alloc_rdy, alloc_slot_0, full);
        end
        alloc(1, 1, 5'd1, 1, 5'd2);
        next_cycle(); idle(); #2;
        tests++;
        if (count !== 6'd31) begin
            fails++;
            $display("FAIL wrap_ignore: count=%0d, required 31", count);
        end
        fill(1, 5'd0, 0, 5'd0);
        next_cycle(); idle(); #2;
        tests++;
        if (commit_val_1 !== !BYP || count !== (BYP ? 6'd30 : 6'd31) || alloc_rdy !== BYP) begin
            fails++;
            $display("FAIL wrap_commit: val1=%b count=%0d rdy=%b, bypass=%b", commit_val_1, count, alloc_rdy, BYP);
        end
        next_cycle(); #2;
        tests++;
        if (count !== 6'd30 || alloc_rdy !== 1'b1 || alloc_slot_0 !== 5'd31 || alloc_slot_1 !== 5'd0) begin
            fails++;
            $display("FAIL wrap_credit: count=%0d rdy=%b slots=%0d,%0d, required 30 1 31,0",
                     count, alloc_rdy, alloc_slot_0, alloc_slot_1);
        end
        alloc(1, 1, 5'd7, 1, 5'd8);
        next_cycle(); idle(); #2;
        tests++;
        if (count !== 6'd32 || full !== 1'b1 || alloc_rdy !== 1'b0 || alloc_slot_0 !== 5'd1) begin
            fails++;
            $display("FAIL wrap_full: count=%0d full=%b rdy=%b slot0=%0d, required 32 1 0 1",
                     count, full, alloc_rdy, alloc_slot_0);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(1, 1, 5'(i), 1, 5'(i));
            next_cycle();
        end
        idle(); #2;
        tests++;
        if (count !== 6'd32 || full !== 1'b1) begin
            fails++;
            $display("FAIL flush_fill_up: count=%0d full=%b, required 32 1", count, full);
        end
        fill(1, 5'd0, 0, 5'd0);
        next_cycle(); idle();
        flush = 1'b1;
        alloc(0, 1, 5'd7, 0, 5'd0);
        fill(1, 5'd1, 0, 5'd0);
        #2;
        tests++;
        if (commit_val_1 !== 1'b0 || commit_val_2 !== 1'b0) begin
            fails++;
            $display("FAIL flush_commit: val=%b%b, required 00", commit_val_1, commit_val_2);
        end
        next_cycle(); idle(); #2;
        tests++;
        if (count !== 6'd0 || empty !== 1'b1 || alloc_slot_0 !== 5'd0 || commit_val_1 !== 1'b0) begin
            fails++;
            $display("FAIL flush_state: count=%0d empty=%b slot0=%0d val1=%b, required 0 1 0 0",
                     count, empty, alloc_slot_0, commit_val_1);
        end
        alloc(0, 1, 5'd7, 0, 5'd0);
        next_cycle(); idle();
        next_cycle(); #2;
        tests++;
        if (commit_val_1 !== 1'b0 || count !== 6'd1) begin
            fails++;
            $display("FAIL flush_stale_filled: val1=%b count=%0d, required 0 1", commit_val_1, count);
        end
    endtask

    task automatic test_wen0();
        do_reset();
        alloc(0, 0, 5'd9, 0, 5'd0);
        next_cycle(); idle();
        fill(0, 5'd0, 1, 5'd0);
        #2;
        tests++;
        if (commit_val_1 !== BYP || commit_wen_1 !== 1'b0 || commit_waddr_1 !== (BYP ? 5'd9 : 5'd0)) begin
            fails++;
            $display("FAIL wen0_fill_cycle: val1=%b wen1=%b waddr1=%0d, bypass=%b",
                     commit_val_1, commit_wen_1, commit_waddr_1, BYP);
        end
        next_cycle(); idle(); #2;
        tests++;
        if (commit_val_1 !== !BYP || commit_wen_1 !== 1'b0 || commit_waddr_1 !== (BYP ? 5'd0 : 5'd9)) begin
            fails++;
            $display("FAIL wen0_next_cycle: val1=%b wen1=%b waddr1=%0d, bypass=%b",
                     commit_val_1, commit_wen_1, commit_waddr_1, BYP);
        end
        next_cycle(); #2;
        tests++;
        if (count !== 6'd0) begin
            fails++;
            $display("FAIL wen0_drain: count=%0d, required 0", count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc(1, 1, 5'd1, 1, 5'd2); next_cycle();
        alloc(1, 1, 5'd3, 1, 5'd4); next_cycle();
        alloc(0, 1, 5'd5, 0, 5'd0); next_cycle();
        idle();
        fill(1, 5'd0, 1, 5'd1);
        next_cycle(); idle(); #2;
        tests++;
        if (count !== (BYP ? 6'd3 : 6'd5) || commit_val_1 !== !BYP) begin
            fails++;
            $display("FAIL async_setup: count=%0d val1=%b, bypass=%b", count, commit_val_1, BYP);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || alloc_rdy !== 1'b1 ||
            alloc_slot_0 !== 5'd0 || alloc_slot_1 !== 5'd1 ||
            {commit_val_1, commit_val_2, commit_wen_1, commit_wen_2} !== 4'b0 ||
            commit_slot_1 !== 5'd0 || commit_slot_2 !== 5'd0 ||
            commit_waddr_1 !== 5'd0 || commit_waddr_2 !== 5'd0) begin
            fails++;
            $display("FAIL async_reset: count=%0d empty=%b rdy=%b slots=%0d,%0d val=%b%b, required reset values",
                     count, empty, alloc_rdy, alloc_slot_0, alloc_slot_1, commit_val_1, commit_val_2);
        end
        next_cycle();
        reset = 1'b1;
        fill(1, 5'd2, 1, 5'd3);
        repeat (3) next_cycle();
        idle(); #2;
        tests++;
        if (commit_val_1 !== 1'b0 || count !== 6'd0) begin
            fails++;
            $display("FAIL async_abandon: val1=%b count=%0d, required 0 0", commit_val_1, count);
        end
    endtask

    task automatic test_random();
        ent_t       q[$];
        ent_t       e;
        logic [4:0] tslot;
        int         size, ap;
        bit         erdy, ec1, ec2, ew1, ew2;
        logic [4:0] es1, es2, ea1, ea2;
        do_reset();
        tslot = 5'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ap = ((cyc / 200) % 2 == 1) ? 85 : 35;
            alloc_val_0   = ($urandom_range(99) < ap);
            alloc_val_1   = 1'($urandom_range(1));
            alloc_wen_0   = 1'($urandom_range(1));
            alloc_wen_1   = 1'($urandom_range(1));
            alloc_waddr_0 = 5'($urandom);
            alloc_waddr_1 = 5'($urandom);
            fill_wen_A    = 1'($urandom_range(1));
            fill_wen_B    = 1'($urandom_range(1));
            fill_slot_A   = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].slot : 5'($urandom);
            fill_slot_B   = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].slot : 5'($urandom);
            flush         = ($urandom_range(99) == 0);
            #2;
            size = q.size();
            erdy = (DEPTH - size) >= 2;
            ec1  = !flush && size >= 1 && (q[0].filled || (BYP && hit(q[0].slot)));
            ec2  = ec1 && size >= 2 && (q[1].filled || (BYP && hit(q[1].slot)));
            ew1  = ec1 && q[0].wen;
            ew2  = ec2 && q[1].wen;
            es1  = ec1 ? q[0].slot : 5'd0;
            es2  = ec2 ? q[1].slot : 5'd0;
            ea1  = ec1 ? q[0].waddr : 5'd0;
            ea2  = ec2 ? q[1].waddr : 5'd0;
            tests++;
            if (count !== 6'(size) || empty !== (size == 0) || full !== (size == DEPTH)) begin
                fails++;
                $display("FAIL rand_occ cyc=%0d: count=%0d empty=%b full=%b, required %0d", cyc, count, empty, full, size);
            end
            tests++;
            if (alloc_rdy !== erdy || alloc_slot_0 !== tslot || alloc_slot_1 !== tslot + 5'd1) begin
                fails++;
                $display("FAIL rand_alloc cyc=%0d: rdy=%b slot0=%0d, required %b %0d", cyc, alloc_rdy, alloc_slot_0, erdy, tslot);
            end
            tests++;
            if ({commit_val_1, commit_val_2} !== {ec1, ec2} || {commit_wen_1, commit_wen_2} !== {ew1, ew2}) begin
                fails++;
                $display("FAIL rand_commit cyc=%0d: val=%b%b wen=%b%b, required %b%b %b%b",
                         cyc, commit_val_1, commit_val_2, commit_wen_1, commit_wen_2, ec1, ec2, ew1, ew2);
            end
            tests++;
            if (commit_slot_1 !== es1 || commit_slot_2 !== es2 || commit_waddr_1 !== ea1 || commit_waddr_2 !== ea2) begin
                fails++;
                $display("FAIL rand_payload cyc=%0d: slot=%0d,%0d waddr=%0d,%0d, required %0d,%0d %0d,%0d",
                         cyc, commit_slot_1, commit_slot_2, commit_waddr_1, commit_waddr_2, es1, es2, ea1, ea2);
            end
            if (flush) begin
                q.delete();
                tslot = 5'd0;
            end else begin
                foreach (q[i]) if (hit(q[i].slot)) q[i].filled = 1'b1;
                if (ec1) void'(q.pop_front());
                if (ec2) void'(q.pop_front());
                if (erdy && alloc_val_0) begin
                    e.slot = tslot; e.wen = alloc_wen_0; e.waddr = alloc_waddr_0; e.filled = 1'b0;
                    q.push_back(e);
                    tslot = tslot + 5'd1;
                    if (alloc_val_1) begin
                        e.slot = tslot; e.wen = alloc_wen_1; e.waddr = alloc_waddr_1; e.filled = 1'b0;
                        q.push_back(e);
                        tslot = tslot + 5'd1;
                    end
                end
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alloc_pair();
        test_fill_order();
        test_full_wrap();
        test_flush();
        test_wen0();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
